// File: rtl/hdr_ddr_rx_pkg.sv
// Shared definitions for the I3C HDR-DDR receive path: rx mode codes, error codes,
// CRC5 constants and the deserialiser FSM state type.
package hdr_ddr_rx_pkg;

  localparam logic [3:0] ModePreamble = 4'b0000;
  localparam logic [3:0] ModeData     = 4'b0011;
  localparam logic [3:0] ModeToken    = 4'b0101;
  localparam logic [3:0] ModeParity   = 4'b0110;
  localparam logic [3:0] ModeCrc      = 4'b0111;

  localparam logic [1:0] ErrNone   = 2'b00;
  localparam logic [1:0] ErrParity = 2'b01;
  localparam logic [1:0] ErrToken  = 2'b10;
  localparam logic [1:0] ErrCrc    = 2'b11;

  localparam int unsigned         CrcW    = 5;
  localparam logic [CrcW-1:0]     CrcPoly = 5'b00101;  // x^5 + x^2 + 1, x^5 implicit
  localparam logic [CrcW-1:0]     CrcSeed = 5'h1F;

  typedef enum logic [0:0] {StIdle, StRun} rx_state_e;

  // One serial CRC step, message bit enters at the top.
  function automatic logic [CrcW-1:0] crc5_step(input logic [CrcW-1:0] crc, input logic b);
    logic fb;
    fb = crc[CrcW-1] ^ b;
    return {crc[CrcW-2:0], 1'b0} ^ (fb ? CrcPoly : '0);
  endfunction

endpackage

// File: rtl/hdr_ddr_rx_deser_if.sv
// Bus between the DDR CCC controller / SCL gen / SDA handler and the HDR-DDR receiver.
// The receiver uses the slave modport; the driving side uses master.
interface hdr_ddr_rx_deser_if #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned PRE_BITS = 2
);

  logic              i_sclgen_scl_pos_edge;
  logic              i_sclgen_scl_neg_edge;
  logic              i_ddrccc_rx_en;
  logic [3:0]        i_ddrccc_rx_mode;
  logic              i_sdahnd_rx_sda;
  logic [DATA_W-1:0] o_regfcrc_rx_data_out;
  logic              o_regfcrc_rx_data_valid;
  logic [PRE_BITS-1:0] o_ddrccc_pre;
  logic              o_ddrccc_rx_mode_done;
  logic              o_ddrccc_error;
  logic [1:0]        o_ddrccc_error_type;

  modport master (
    output i_sclgen_scl_pos_edge, i_sclgen_scl_neg_edge, i_ddrccc_rx_en, i_ddrccc_rx_mode,
    output i_sdahnd_rx_sda,
    input  o_regfcrc_rx_data_out, o_regfcrc_rx_data_valid, o_ddrccc_pre,
    input  o_ddrccc_rx_mode_done, o_ddrccc_error, o_ddrccc_error_type
  );

  modport slave (
    input  i_sclgen_scl_pos_edge, i_sclgen_scl_neg_edge, i_ddrccc_rx_en, i_ddrccc_rx_mode,
    input  i_sdahnd_rx_sda,
    output o_regfcrc_rx_data_out, o_regfcrc_rx_data_valid, o_ddrccc_pre,
    output o_ddrccc_rx_mode_done, o_ddrccc_error, o_ddrccc_error_type
  );

endinterface

// File: rtl/hdr_ddr_crc5.sv
// Serial CRC5 (x^5+x^2+1, seed all-ones) over the received DATA bits.
module hdr_ddr_crc5
  import hdr_ddr_rx_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            bit_en,
  input  logic            bit_in,
  output logic [CrcW-1:0] crc_out
);

  logic [CrcW-1:0] crc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_q <= CrcSeed;
    end else if (clear) begin
      crc_q <= CrcSeed;
    end else if (bit_en) begin
      crc_q <= crc5_step(crc_q, bit_in);
    end
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/hdr_ddr_rx_deser.sv
// I3C HDR-DDR receive deserialiser: samples SDA on both SCL edges and executes one rx mode
// (preamble, data word, token, parity, CRC) per request from the DDR CCC controller.
module hdr_ddr_rx_deser
  import hdr_ddr_rx_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned PRE_BITS = 2,
  parameter int unsigned CRC_W    = CrcW,
  parameter logic [3:0]  TOKEN    = 4'hC
) (
  input logic               i_sys_clk,
  input logic               i_sys_rst,
  hdr_ddr_rx_deser_if.slave rx
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  function automatic logic [CntW-1:0] mode_bits(input logic [3:0] mode);
    case (mode)
      ModePreamble: return CntW'(PRE_BITS);
      ModeData:     return CntW'(DATA_W);
      ModeToken:    return CntW'(4);
      ModeParity:   return CntW'(2);
      ModeCrc:      return CntW'(CRC_W);
      default:      return '0;
    endcase
  endfunction

  function automatic logic [1:0] word_parity(input logic [DATA_W-1:0] w);
    logic odd;
    logic even;
    odd  = 1'b0;
    even = 1'b1;
    for (int i = 0; i < DATA_W; i += 2) begin
      even ^= w[i];
      odd  ^= w[i+1];
    end
    return {odd, even};
  endfunction

  rx_state_e           state_q;
  logic [3:0]          mode_q, mode_eff;
  logic [CntW-1:0]     cnt_q, bits_eff;
  logic [DATA_W-1:0]   shreg_q, shift_nx, data_q;
  logic [PRE_BITS-1:0] pre_q;
  logic [1:0]          par_q, err_type_q;
  logic                done_q, valid_q, err_q;
  logic                sample, take, last, crc_clear, crc_bit_en;
  logic [CrcW-1:0]     crc_val;

  always_comb begin
    sample   = rx.i_sclgen_scl_pos_edge | rx.i_sclgen_scl_neg_edge;
    // The next mode is taken from the controller in the done cycle, so a sample there
    // already belongs to it.
    mode_eff = done_q ? rx.i_ddrccc_rx_mode : mode_q;
    bits_eff = mode_bits(mode_eff);
    shift_nx = {shreg_q[DATA_W-2:0], rx.i_sdahnd_rx_sda};
    take     = (state_q == StRun) && rx.i_ddrccc_rx_en && sample && (bits_eff != '0);
    last     = take && (cnt_q == bits_eff - CntW'(1));
    crc_clear  = ((state_q == StRun) && !rx.i_ddrccc_rx_en) || (last && (mode_eff == ModeCrc));
    crc_bit_en = take && (mode_eff == ModeData);
  end

  hdr_ddr_crc5 u_crc5 (
    .clk     (i_sys_clk),
    .rst_n   (i_sys_rst),
    .clear   (crc_clear),
    .bit_en  (crc_bit_en),
    .bit_in  (rx.i_sdahnd_rx_sda),
    .crc_out (crc_val)
  );

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst) begin
      state_q    <= StIdle;
      mode_q     <= ModePreamble;
      cnt_q      <= '0;
      shreg_q    <= '0;
      data_q     <= '0;
      pre_q      <= '0;
      par_q      <= '0;
      err_type_q <= ErrNone;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rx.i_ddrccc_rx_en) begin
            state_q <= StRun;
            mode_q  <= rx.i_ddrccc_rx_mode;
            cnt_q   <= '0;
          end
        end
        StRun: begin
          if (!rx.i_ddrccc_rx_en) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            mode_q <= mode_eff;
            if (take) begin
              shreg_q <= shift_nx;
              if (last) begin
                cnt_q  <= '0;
                done_q <= 1'b1;
                case (mode_eff)
                  ModePreamble: pre_q <= shift_nx[PRE_BITS-1:0];
                  ModeData: begin
                    data_q  <= shift_nx;
                    valid_q <= 1'b1;
                    par_q   <= word_parity(shift_nx);
                  end
                  ModeToken: begin
                    err_q      <= (shift_nx[3:0] != TOKEN);
                    err_type_q <= (shift_nx[3:0] != TOKEN) ? ErrToken : ErrNone;
                  end
                  ModeParity: begin
                    err_q      <= (shift_nx[1:0] != par_q);
                    err_type_q <= (shift_nx[1:0] != par_q) ? ErrParity : ErrNone;
                  end
                  ModeCrc: begin
                    err_q      <= (shift_nx[CRC_W-1:0] != crc_val);
                    err_type_q <= (shift_nx[CRC_W-1:0] != crc_val) ? ErrCrc : ErrNone;
                  end
                  default: ;
                endcase
              end else begin
                cnt_q <= cnt_q + CntW'(1);
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rx.o_regfcrc_rx_data_out   = data_q;
  assign rx.o_regfcrc_rx_data_valid = valid_q;
  assign rx.o_ddrccc_pre            = pre_q;
  assign rx.o_ddrccc_rx_mode_done   = done_q;
  assign rx.o_ddrccc_error          = err_q;
  assign rx.o_ddrccc_error_type     = err_type_q;

endmodule

// File: tb/tb_hdr_ddr_rx_deser.sv
// Randomised bench for hdr_ddr_rx_deser against a transaction-level reference model
// (polynomial-division CRC5, bit-count parity, word/abort/reset sequencing).
module tb_hdr_ddr_rx_deser;

  localparam logic [3:0] MPre = 4'b0000;
  localparam logic [3:0] MDat = 4'b0011;
  localparam logic [3:0] MTok = 4'b0101;
  localparam logic [3:0] MPar = 4'b0110;
  localparam logic [3:0] MCrc = 4'b0111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hdr_ddr_rx_deser_if #(.DATA_W(16), .PRE_BITS(2)) rx_if ();

  hdr_ddr_rx_deser #(
    .DATA_W   (16),
    .PRE_BITS (2),
    .CRC_W    (5),
    .TOKEN    (4'hC)
  ) dut (
    .i_sys_clk (clk),
    .i_sys_rst (rst),
    .rx        (rx_if)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  int n_valid = 0;
  bit crcq[$];
  logic [1:0] exp_par;
  logic got_done, got_valid, got_err;
  logic [1:0] got_type, got_pre;
  logic [15:0] got_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Remainder of (seed * x^n + M(x) * x^5) mod (x^5 + x^2 + 1)
  function automatic logic [4:0] crc_model(input bit q[$]);
    logic [127:0] d;
    int n;
    n = q.size();
    d = '0;
    d[n +: 5] = 5'h1F;
    for (int i = 0; i < n; i++) d[5 + n - 1 - i] ^= q[i];
    for (int k = n + 4; k >= 5; k--) if (d[k]) d[k-5 +: 6] ^= 6'b100101;
    return d[4:0];
  endfunction

  function automatic logic [1:0] parity_model(input logic [15:0] w);
    int odd_ones = 0;
    int even_ones = 0;
    for (int i = 0; i < 16; i++) if (w[i]) begin
      if (i % 2 == 1) odd_ones++;
      else even_ones++;
    end
    return {(odd_ones % 2 == 1), (even_ones % 2 == 0)};
  endfunction

  always @(negedge clk) if (rst) begin
    if (rx_if.o_ddrccc_rx_mode_done) n_done++;
    if (rx_if.o_regfcrc_rx_data_valid) n_valid++;
  end

  // Sends n bits of val MSB first; the next mode is presented in the done cycle.
  task automatic run_bits(input logic [31:0] val, input int n, input logic [3:0] next_mode,
                          input bit partial);
    for (int i = n - 1; i >= 0; i--) begin
      int sel = $urandom_range(0, 2);
      rx_if.i_sdahnd_rx_sda       = val[i];
      rx_if.i_sclgen_scl_pos_edge = (sel != 1);
      rx_if.i_sclgen_scl_neg_edge = (sel != 0);
      @(negedge clk);
      rx_if.i_sclgen_scl_pos_edge = 1'b0;
      rx_if.i_sclgen_scl_neg_edge = 1'b0;
      if (i == 0 && !partial) begin
        rx_if.i_ddrccc_rx_mode = next_mode;
        got_done  = rx_if.o_ddrccc_rx_mode_done;
        got_valid = rx_if.o_regfcrc_rx_data_valid;
        got_err   = rx_if.o_ddrccc_error;
        got_type  = rx_if.o_ddrccc_error_type;
        got_data  = rx_if.o_regfcrc_rx_data_out;
        got_pre   = rx_if.o_ddrccc_pre;
        chk("done_pulse", got_done, 1);
      end else begin
        chk("no_early_done", rx_if.o_ddrccc_rx_mode_done, 0);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic run_data(input logic [15:0] w, input logic [3:0] next_mode);
    run_bits({16'h0, w}, 16, next_mode, 1'b0);
    chk("data_valid", got_valid, 1);
    chk("data_out", got_data, w);
    chk("data_err", got_err, 0);
    for (int i = 15; i >= 0; i--) crcq.push_back(w[i]);
    exp_par = parity_model(w);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"}, rx_if.o_regfcrc_rx_data_out, 0);
    chk({tag, "_valid"}, rx_if.o_regfcrc_rx_data_valid, 0);
    chk({tag, "_pre"}, rx_if.o_ddrccc_pre, 0);
    chk({tag, "_done"}, rx_if.o_ddrccc_rx_mode_done, 0);
    chk({tag, "_err"}, rx_if.o_ddrccc_error, 0);
    chk({tag, "_etype"}, rx_if.o_ddrccc_error_type, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd0, nv0;
    logic [15:0] w;
    logic [1:0] pv;
    logic [3:0] tok;
    logic [4:0] cv;
    bit bad;

    rst = 1'b0;
    rx_if.i_ddrccc_rx_en        = 1'b0;
    rx_if.i_ddrccc_rx_mode      = MPre;
    rx_if.i_sclgen_scl_pos_edge = 1'b0;
    rx_if.i_sclgen_scl_neg_edge = 1'b0;
    rx_if.i_sdahnd_rx_sda       = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");

    rst = 1'b1;
    @(negedge clk);
    rx_if.i_ddrccc_rx_en = 1'b1;
    repeat (2) @(negedge clk);

    run_bits(32'b10, 2, MDat, 1'b0);
    chk("pre", got_pre, 2'b10);
    chk("pre_err", got_err, 0);

    run_data(16'hA55A, MPar);
    chk("par_model_a55a", exp_par, 2'b01);
    run_bits(32'b01, 2, MDat, 1'b0);
    chk("par_ok_err", got_err, 0);

    run_data(16'hA55A, MPar);
    run_bits(32'b10, 2, MTok, 1'b0);
    chk("par_bad_err", got_err, 1);
    chk("par_bad_type", got_type, 2'b01);

    run_bits(32'hD, 4, MCrc, 1'b0);
    chk("tok_bad_err", got_err, 1);
    chk("tok_bad_type", got_type, 2'b10);
    run_bits({27'h0, crc_model(crcq)}, 5, MDat, 1'b0);
    chk("crc_ok_err", got_err, 0);
    crcq.delete();

    // Random frames: 1-2 words, parity each, token, CRC; some fields corrupted
    for (int it = 0; it < 14; it++) begin
      int nw = $urandom_range(1, 2);
      for (int k = 0; k < nw; k++) begin
        w = 16'($urandom);
        run_data(w, MPar);
        bad = ($urandom_range(0, 3) == 0);
        pv  = bad ? (exp_par ^ 2'($urandom_range(1, 3))) : exp_par;
        run_bits({30'h0, pv}, 2, (k == nw - 1) ? MTok : MDat, 1'b0);
        chk("rnd_par_err", got_err, 32'(bad));
        if (bad) chk("rnd_par_type", got_type, 2'b01);
      end
      bad = ($urandom_range(0, 3) == 0);
      tok = bad ? (4'hC ^ 4'($urandom_range(1, 15))) : 4'hC;
      run_bits({28'h0, tok}, 4, MCrc, 1'b0);
      chk("rnd_tok_err", got_err, 32'(bad));
      if (bad) chk("rnd_tok_type", got_type, 2'b10);
      bad = ($urandom_range(0, 2) == 0);
      cv  = crc_model(crcq) ^ (bad ? (5'd1 << $urandom_range(0, 4)) : 5'd0);
      run_bits({27'h0, cv}, 5, MDat, 1'b0);
      chk("rnd_crc_err", got_err, 32'(bad));
      if (bad) chk("rnd_crc_type", got_type, 2'b11);
      crcq.delete();
    end

    // Abort after 9 of 16 data bits
    @(negedge clk); #1;
    nd0 = n_done;
    nv0 = n_valid;
    run_bits(32'h1234 >> 7, 9, MDat, 1'b1);
    rx_if.i_ddrccc_rx_en = 1'b0;
    repeat (2) @(negedge clk);
    rx_if.i_ddrccc_rx_en = 1'b1;
    repeat (2) @(negedge clk); #1;
    chk("abort_no_done", n_done - nd0, 0);
    chk("abort_no_valid", n_valid - nv0, 0);
    crcq.delete();
    run_data(16'h1234, MTok);
    run_bits(32'hC, 4, MCrc, 1'b0);
    chk("abort_tok_err", got_err, 0);
    run_bits({27'h0, crc_model(crcq)}, 5, MDat, 1'b0);
    chk("abort_crc_err", got_err, 0);
    crcq.delete();

    // Reset mid-word after 5 data bits
    run_bits(32'hBEEF >> 11, 5, MDat, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    rst = 1'b1;
    #1;
    nd0 = n_done;
    repeat (2) @(negedge clk);
    run_data(16'h1234, MTok);
    @(negedge clk); #1;
    chk("rst_one_done", n_done - nd0, 1);
    run_bits(32'hC, 4, MCrc, 1'b0);
    chk("rst_tok_err", got_err, 0);
    run_bits({27'h0, crc_model(crcq)}, 5, MDat, 1'b0);
    chk("rst_crc_err", got_err, 0);
    crcq.delete();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
